elink_deser_gearbox: RTL

- Clocked, parametrised successor to the combinational 2-bit-to-10-bit e-link word assembler.
- Collects IN_W-bit e-link slices into OUT_W-bit encoded words, for example 8b10b symbols, and emits each completed word with a one-cycle valid strobe.
- Provides manual slice-slip alignment, optional automatic comma (K28.5) alignment, and a lock indicator.
- Sits between the e-link sampler and the 8b10b decoder in each mopshub e-link receive channel.

---
 rtl/mopshub_elink_pkg.sv | 27 ++
 rtl/elink_comma_match.sv | 21 ++
 rtl/elink_deser_gearbox.sv | 121 ++++++++++++
 3 files changed

// File: rtl/mopshub_elink_pkg.sv
// Shared definitions for the mopshub e-link receive and transmit channels.
//   - Default slice and word widths for the e-link path.
//   - K28.5 comma patterns in both running-disparity forms.
//   - A constant-evaluable ceiling-log2 helper for sizing counters.
package mopshub_elink_pkg;

   localparam int ELINK_IN_W  = 2;
   localparam int ELINK_OUT_W = 10;

   // K28.5, running-disparity-negative and running-disparity-positive forms.
   localparam logic [9:0] COMMA_P = 10'b0011111010;
   localparam logic [9:0] COMMA_N = 10'b1100000101;

   // Ceiling log2. Returns 0 for value <= 1.
   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/elink_comma_match.sv
// Combinational comma detector.
// Compares an OUT_W-bit window against both disparity forms of the comma.
// Shared by the receive gearbox and the transmit-side checker.
//
// Ports:
//   win   - in,  OUT_W : window to test
//   match - out, 1     : window equals PAT_P or PAT_N
module elink_comma_match
   import mopshub_elink_pkg::*;
#(
   parameter int               OUT_W = ELINK_OUT_W,
   parameter logic [OUT_W-1:0] PAT_P = OUT_W'(mopshub_elink_pkg::COMMA_P),
   parameter logic [OUT_W-1:0] PAT_N = OUT_W'(mopshub_elink_pkg::COMMA_N)
) (
   input  logic [OUT_W-1:0] win,
   output logic             match
);

   assign match = (win == PAT_P) || (win == PAT_N);

endmodule

// File: rtl/elink_deser_gearbox.sv
// E-link deserialising gearbox.
// Collects IN_W-bit slices into OUT_W-bit words and emits each word with a
// one-cycle valid strobe. Supports manual bitslip and, optionally, automatic
// re-framing on a K28.5 comma. Synchronous active-high reset.
//
// Ports:
//   clk        - in,  1     : system clock
//   rst        - in,  1     : synchronous active-high reset
//   din_valid  - in,  1     : din carries a new slice this cycle
//   din        - in,  IN_W  : e-link slice
//   bitslip    - in,  1     : drop the current slice (shifts word boundary)
//   word_out   - out, OUT_W : last assembled word, registered and held
//   word_valid - out, 1     : one-cycle pulse when word_out updates
//   comma_det  - out, 1     : pulse with word_valid when the word is a comma
//   locked     - out, 1     : word boundary established
//   phase      - out, PH_W  : slice index within the current word
module elink_deser_gearbox
   import mopshub_elink_pkg::*;
#(
   parameter int               IN_W      = ELINK_IN_W,
   parameter int               OUT_W     = ELINK_OUT_W,
   parameter int               LSB_FIRST = 1,
   parameter int               COMMA_EN  = 1,
   parameter logic [OUT_W-1:0] COMMA_P   = OUT_W'(mopshub_elink_pkg::COMMA_P),
   parameter logic [OUT_W-1:0] COMMA_N   = OUT_W'(mopshub_elink_pkg::COMMA_N),
   localparam int              DEPTH     = OUT_W / IN_W,
   localparam int              PH_W      = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             din_valid,
   input  logic [IN_W-1:0]  din,
   input  logic             bitslip,
   output logic [OUT_W-1:0] word_out,
   output logic             word_valid,
   output logic             comma_det,
   output logic             locked,
   output logic [PH_W-1:0]  phase
);

   if ((OUT_W % IN_W) != 0 || OUT_W < IN_W) begin : g_bad_width
      $error("elink_deser_gearbox: OUT_W (%0d) must be an integer multiple of IN_W (%0d)",
             OUT_W, IN_W);
   end

   localparam logic [PH_W-1:0] LAST_PHASE = PH_W'(DEPTH - 1);

   logic [OUT_W-1:0] win;
   logic [OUT_W-1:0] win_next;
   logic             accept;
   logic             slip;
   logic             last_slice;
   logic             win_is_comma;
   logic             comma_hit;

   // Shifting through a concatenation keeps every bit of win referenced,
   // and degenerates to win_next = din when DEPTH == 1.
   if (LSB_FIRST != 0) begin : g_lsb_first
      assign win_next = OUT_W'({din, win} >> IN_W);
   end else begin : g_msb_first
      assign win_next = OUT_W'({win, din});
   end

   elink_comma_match #(
      .OUT_W (OUT_W),
      .PAT_P (COMMA_P),
      .PAT_N (COMMA_N)
   ) u_comma_match (
      .win   (win_next),
      .match (win_is_comma)
   );

   assign accept     = din_valid && !bitslip;
   assign slip       = din_valid && bitslip;
   assign last_slice = (phase == LAST_PHASE);
   assign comma_hit  = (COMMA_EN != 0) && win_is_comma;

   // NOTE: all state here is sequential and uses non-blocking assignments so
   // every register samples the pre-edge values of its neighbours; blocking
   // assignments would make the result depend on statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         win        <= '0;
         word_out   <= '0;
         phase      <= '0;
         word_valid <= 1'b0;
         comma_det  <= 1'b0;
         locked     <= 1'b0;
      end else begin
         // Strobes default low; they are raised only on an emitting slice.
         word_valid <= 1'b0;
         comma_det  <= 1'b0;

         if (slip) begin
            // Dropped slice: window and phase untouched, boundary no longer trusted.
            locked <= 1'b0;
         end else if (accept) begin
            win <= win_next;
            if (comma_hit) begin
               // Comma re-frames the boundary regardless of the current phase;
               // a comma landing on the last slice still emits only once.
               word_out   <= win_next;
               word_valid <= 1'b1;
               comma_det  <= 1'b1;
               locked     <= 1'b1;
               phase      <= '0;
            end else if (last_slice) begin
               word_out   <= win_next;
               word_valid <= 1'b1;
               phase      <= '0;
               if (COMMA_EN == 0) begin
                  locked <= 1'b1;
               end
            end else begin
               phase <= phase + 1'b1;
            end
         end
      end
   end

endmodule
